// File: rtl/debounce_pkg.sv
// Shared types and parameter legality check for the multi-channel button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW,
    ST_RISE,
    ST_HIGH,
    ST_FALL
  } state_t;

  // True when the parameter set is legal and every threshold fits in the counter.
  function automatic bit params_ok(input int num_ch, input int cnt_w, input int rise_clks,
                                   input int fall_clks, input int pulse_clks,
                                   input int rep_clks);
    int max_v;
    max_v = rise_clks;
    if (fall_clks > max_v) max_v = fall_clks;
    if (rep_clks > max_v) max_v = rep_clks;
    return (num_ch >= 1) && (cnt_w >= 1) && (cnt_w <= 31) &&
           (rise_clks >= 1) && (fall_clks >= 1) &&
           (pulse_clks >= 1) && (pulse_clks <= rise_clks) && (pulse_clks <= fall_clks) &&
           ((rep_clks == 0) || (rep_clks > pulse_clks)) &&
           ((max_v >> cnt_w) == 0);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, rise/fall qualification FSM,
// registered level and press/release one-shot pulses with optional auto-repeat.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int RISE_CLKS   = 25,
  parameter int FALL_CLKS   = 50,
  parameter int PULSE_CLKS  = 1,
  parameter int REPEAT_CLKS = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic db_level,
  output logic press,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] RISE_C     = CNT_W'(RISE_CLKS);
  localparam logic [CNT_W-1:0] FALL_C     = CNT_W'(FALL_CLKS);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CLKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_CLKS - 1);

  logic s1, s2;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pcnt_q;
  logic db_d;
  logic start_press, start_rel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      db_level <= 1'b0;
    end else begin
      s1       <= btn;
      s2       <= s1;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      db_level <= db_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    db_d        = db_level;
    start_press = 1'b0;
    start_rel   = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (s2) begin
          state_d = ST_RISE;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_RISE: begin
        if (!s2) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == RISE_C) begin
          state_d     = ST_HIGH;
          cnt_d       = '0;
          db_d        = 1'b1;
          start_press = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // While held, cnt doubles as the auto-repeat timer.
      ST_HIGH: begin
        if (!s2) begin
          state_d = ST_FALL;
          cnt_d   = CNT_W'(1);
        end else if (REPEAT_CLKS != 0) begin
          if (cnt_q == REP_LAST) begin
            cnt_d       = '0;
            start_press = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_FALL: begin
        if (s2) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == FALL_C) begin
          state_d   = ST_LOW;
          cnt_d     = '0;
          db_d      = 1'b0;
          start_rel = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulses never overlap on one channel, so a single width counter serves both outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      pcnt_q        <= '0;
    end else if (start_press) begin
      press         <= 1'b1;
      release_pulse <= 1'b0;
      pcnt_q        <= PULSE_LAST;
    end else if (start_rel) begin
      press         <= 1'b0;
      release_pulse <= 1'b1;
      pcnt_q        <= PULSE_LAST;
    end else if (pcnt_q != '0) begin
      pcnt_q <= pcnt_q - CNT_W'(1);
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// N-channel button conditioner: per-channel polarity select and debounce,
// plus a registered any-event flag covering every press and release pulse.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int                NUM_CH      = 4,
  parameter int                CNT_W       = 8,
  parameter int                RISE_CLKS   = 25,
  parameter int                FALL_CLKS   = 50,
  parameter int                PULSE_CLKS  = 1,
  parameter int                REPEAT_CLKS = 0,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW  = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] BTN,
  output logic [NUM_CH-1:0] DB_LEVEL,
  output logic [NUM_CH-1:0] PRESS,
  output logic [NUM_CH-1:0] RELEASE,
  output logic              ANY_EVT
);

  if (!params_ok(NUM_CH, CNT_W, RISE_CLKS, FALL_CLKS, PULSE_CLKS, REPEAT_CLKS)) begin : g_param_err
    $error("debounce_multi: illegal parameter combination");
  end

  logic [NUM_CH-1:0] btn_active;

  assign btn_active = BTN ^ ACTIVE_LOW;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W      (CNT_W),
      .RISE_CLKS  (RISE_CLKS),
      .FALL_CLKS  (FALL_CLKS),
      .PULSE_CLKS (PULSE_CLKS),
      .REPEAT_CLKS(REPEAT_CLKS)
    ) u_ch (
      .clk          (CLK),
      .rst_n        (RST_N),
      .btn          (btn_active[i]),
      .db_level     (DB_LEVEL[i]),
      .press        (PRESS[i]),
      .release_pulse(RELEASE[i])
    );
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ANY_EVT <= 1'b0;
    end else begin
      ANY_EVT <= |(PRESS | RELEASE);
    end
  end

endmodule
